// File: rtl/golden_compare_pkg.sv
// Shared types, default widths and the masked-compare helper for the golden compare sequencer.
package golden_compare_pkg;

    localparam int unsigned TV_W_DEF      = 70;
    localparam int unsigned RV_W_DEF      = 41;
    localparam int unsigned START_BIT_DEF = 69;
    localparam int unsigned READY_BIT_DEF = 32;
    localparam int unsigned NUM_CH_DEF    = 1;
    localparam int unsigned CNT_W_DEF     = 32;
    localparam int unsigned TIMEOUT_DEF   = 64;
    // Widest result vector the compare helper accepts
    localparam int unsigned CMP_MAX_W     = 256;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CMP,
        REPORT
    } state_e;

    // True when any unmasked bit differs between two zero-extended result vectors
    function automatic logic masked_ne(input logic [CMP_MAX_W-1:0] a,
                                       input logic [CMP_MAX_W-1:0] b,
                                       input logic [CMP_MAX_W-1:0] mask);
        return |((a ^ b) & mask);
    endfunction

endpackage

// File: rtl/golden_compare_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count register: clear first, then increment until all ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/golden_compare_sequencer.sv
// Drives one test vector into golden + faulty circuits, compares masked results per channel.
module golden_compare_sequencer
    import golden_compare_pkg::*;
#(
    parameter int unsigned     TV_W      = TV_W_DEF,
    parameter int unsigned     RV_W      = RV_W_DEF,
    parameter int unsigned     START_BIT = START_BIT_DEF,
    parameter int unsigned     READY_BIT = READY_BIT_DEF,
    parameter int unsigned     NUM_CH    = NUM_CH_DEF,
    parameter int unsigned     CNT_W     = CNT_W_DEF,
    parameter int unsigned     TIMEOUT   = TIMEOUT_DEF,
    parameter logic [RV_W-1:0] RV_MASK   = {RV_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tv_valid,
    input  logic [TV_W-1:0]         tv_data,
    output logic                    tv_ready,
    output logic [TV_W-1:0]         dut_tv,
    input  logic [RV_W-1:0]         golden_rv,
    input  logic [NUM_CH*RV_W-1:0]  faulty_rv,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NUM_CH-1:0]       res_mismatch,
    output logic                    res_timeout,
    input  logic                    clr_cnt,
    output logic [NUM_CH*CNT_W-1:0] err_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e                   state_q, state_d;
    logic [TV_W-1:0]          dut_tv_q, dut_tv_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [NUM_CH-1:0]        mism_q, mism_d;
    logic                     timeout_q, timeout_d;
    logic [RV_W-1:0]          cap_gold_q, cap_gold_d;
    logic [NUM_CH*RV_W-1:0]   cap_faulty_q, cap_faulty_d;
    logic [NUM_CH-1:0]        cmp_c;
    logic [NUM_CH-1:0]        inc_c;

    // Masked per-channel compare of the results captured at the golden ready instant
    always_comb begin
        cmp_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cmp_c[c] = masked_ne(CMP_MAX_W'(cap_gold_q),
                                 CMP_MAX_W'(cap_faulty_q[c*RV_W +: RV_W]),
                                 CMP_MAX_W'(RV_MASK));
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        dut_tv_d     = dut_tv_q;
        timer_d      = timer_q;
        mism_d       = mism_q;
        timeout_d    = timeout_q;
        cap_gold_d   = cap_gold_q;
        cap_faulty_d = cap_faulty_q;
        inc_c        = '0;
        case (state_q)
            IDLE: begin
                if (tv_valid) begin
                    dut_tv_d            = tv_data;
                    dut_tv_d[START_BIT] = 1'b1;
                    state_d             = LAUNCH;
                end
            end
            LAUNCH: begin
                dut_tv_d[START_BIT] = 1'b0;
                timer_d             = '0;
                state_d             = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (golden_rv[READY_BIT]) begin
                    cap_gold_d   = golden_rv;
                    cap_faulty_d = faulty_rv;
                    state_d      = CMP;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    // Last WAIT cycle: result rises TIMEOUT+3 cycles after acceptance
                    timeout_d = 1'b1;
                    mism_d    = '0;
                    state_d   = REPORT;
                end
            end
            CMP: begin
                mism_d    = cmp_c;
                timeout_d = 1'b0;
                inc_c     = cmp_c;
                state_d   = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any vector in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            dut_tv_q     <= '0;
            timer_q      <= '0;
            mism_q       <= '0;
            timeout_q    <= 1'b0;
            cap_gold_q   <= '0;
            cap_faulty_q <= '0;
        end else begin
            state_q      <= state_d;
            dut_tv_q     <= dut_tv_d;
            timer_q      <= timer_d;
            mism_q       <= mism_d;
            timeout_q    <= timeout_d;
            cap_gold_q   <= cap_gold_d;
            cap_faulty_q <= cap_faulty_d;
        end
    end

    // One saturating error counter per faulty channel
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr_cnt),
            .inc (inc_c[g]),
            .cnt (err_cnt[g*CNT_W +: CNT_W])
        );
    end

    assign tv_ready     = (state_q == IDLE);
    assign res_valid    = (state_q == REPORT);
    assign dut_tv       = dut_tv_q;
    assign res_mismatch = mism_q;
    assign res_timeout  = timeout_q;

endmodule

// File: tb/tb_golden_compare_sequencer.sv
// Scoreboard bench: NUM_CH=2, CNT_W=2, TIMEOUT=8, default vector/result widths.
module tb_golden_compare_sequencer;

    localparam int unsigned TV_W   = 70;
    localparam int unsigned RV_W   = 41;
    localparam int unsigned NCH    = 2;
    localparam int unsigned CW     = 2;
    localparam int unsigned TO     = 8;
    localparam int unsigned SB     = 69;
    localparam int unsigned RB     = 32;

    logic                  clk;
    logic                  rst;
    logic                  tv_valid;
    logic [TV_W-1:0]       tv_data;
    logic                  tv_ready;
    logic [TV_W-1:0]       dut_tv;
    logic [RV_W-1:0]       golden_rv;
    logic [NCH*RV_W-1:0]   faulty_rv;
    logic                  res_valid;
    logic                  res_ready;
    logic [NCH-1:0]        res_mismatch;
    logic                  res_timeout;
    logic                  clr_cnt;
    logic [NCH*CW-1:0]     err_cnt;

    golden_compare_sequencer #(
        .TV_W(TV_W), .RV_W(RV_W), .START_BIT(SB), .READY_BIT(RB),
        .NUM_CH(NCH), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .tv_valid(tv_valid), .tv_data(tv_data),
        .tv_ready(tv_ready), .dut_tv(dut_tv), .golden_rv(golden_rv),
        .faulty_rv(faulty_rv), .res_valid(res_valid), .res_ready(res_ready),
        .res_mismatch(res_mismatch), .res_timeout(res_timeout),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] mm;
        logic           to;
        int             lat;
        logic [CW-1:0]  c0;
        logic [CW-1:0]  c1;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks;
    int           n_errors;
    logic [CW-1:0] mdl_cnt [NCH];

    // Single comparison point
    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // One vector: golden ready at cycle k (k<0: never), channel flips f0/f1,
    // optional counter clear during CMP, and hold cycles with res_ready low.
    task automatic run_vec(input logic [TV_W-1:0] tv, input int k,
                           input logic [RV_W-1:0] f0, input logic [RV_W-1:0] f1,
                           input bit clr_at_cmp, input int hold);
        exp_t           e;
        exp_t           got;
        logic [RV_W-1:0] gold;
        logic [TV_W-1:0] tv_s1;
        logic [TV_W-1:0] tv_s0;
        bit             found;
        int             lat;
        gold  = 41'h0_3F80_0000;
        gold[RB] = 1'b1;
        tv_s1 = tv;  tv_s1[SB] = 1'b1;
        tv_s0 = tv;  tv_s0[SB] = 1'b0;
        e.to  = (k < 0);
        e.mm  = e.to ? '0 : {|f1, |f0};
        e.lat = e.to ? int'(TO) + 3 : k + 2;
        if (clr_at_cmp) begin
            mdl_cnt[0] = '0;
            mdl_cnt[1] = '0;
        end else if (!e.to) begin
            if (e.mm[0]) mdl_cnt[0] = sat_inc(mdl_cnt[0]);
            if (e.mm[1]) mdl_cnt[1] = sat_inc(mdl_cnt[1]);
        end
        e.c0 = mdl_cnt[0];
        e.c1 = mdl_cnt[1];
        sb_q.push_back(e);

        res_ready = (hold == 0);
        @(posedge clk); #1;
        tv_data  = tv;
        tv_valid = 1'b1;
        found = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(posedge clk); #1;
            if (c == 1) tv_valid = 1'b0;
            if (c == k) begin
                golden_rv = gold;
                faulty_rv = {gold ^ f1, gold ^ f0};
            end
            if (c == k + 1) begin
                // Results only count at the ready instant
                golden_rv = '0;
                faulty_rv = '0;
                if (clr_at_cmp) clr_cnt = 1'b1;
            end
            if (c == k + 2) clr_cnt = 1'b0;
            @(negedge clk);
            if (c == 1) chk("dut_tv_start", dut_tv, tv_s1);
            if (c == 2) chk("dut_tv_nostart", dut_tv, tv_s0);
            if (res_valid) begin
                found = 1'b1;
                lat   = c;
            end
        end
        clr_cnt = 1'b0;
        if (!found) begin
            chk("res_valid_timeout", 0, 1);
            void'(sb_q.pop_front());
            return;
        end
        got = sb_q.pop_front();
        chk("latency", lat, got.lat);
        chk("mismatch", res_mismatch, got.mm);
        chk("timeout", res_timeout, got.to);
        chk("err_cnt0", err_cnt[0*CW +: CW], got.c0);
        chk("err_cnt1", err_cnt[1*CW +: CW], got.c1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_mismatch", res_mismatch, got.mm);
            chk("hold_timeout", res_timeout, got.to);
            chk("hold_tv_ready", tv_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_tv_ready", tv_ready, 1);
        chk("post_res_valid", res_valid, 0);
        chk("post_dut_tv", dut_tv, tv_s0);
    endtask

    logic [TV_W-1:0] vec;
    logic [RV_W-1:0] b3;
    logic [RV_W-1:0] brdy;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mdl_cnt[0] = '0;
        mdl_cnt[1] = '0;
        rst       = 1'b0;
        tv_valid  = 1'b0;
        tv_data   = '0;
        golden_rv = '0;
        faulty_rv = '0;
        res_ready = 1'b1;
        clr_cnt   = 1'b0;
        vec  = {6'h00, 32'h3F80_0000, 32'h3F80_0000};
        b3   = 41'h8;
        brdy = '0;
        brdy[RB] = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_tv_ready", tv_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_dut_tv", dut_tv, 0);
        chk("rst_mismatch", res_mismatch, 0);
        chk("rst_timeout", res_timeout, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Clean vector, ready 5 cycles in
        run_vec(vec, 5, '0, '0, 1'b0, 0);
        // Channel 1 flips bit 3, three times
        repeat (3) run_vec(vec, 5, '0, b3, 1'b0, 0);
        // Golden never ready
        run_vec(vec, -1, '0, b3, 1'b0, 0);
        // Two more mismatches: channel 1 stays saturated, channel 0 counts once
        run_vec(vec, 3, b3, b3, 1'b0, 0);
        run_vec(vec, 2, '0, b3, 1'b0, 0);
        // Clear coinciding with an increment
        run_vec(vec, 4, b3, b3, 1'b1, 0);
        // Result held for 10 cycles
        run_vec(vec ^ 70'h1234, 6, b3, '0, 1'b0, 10);
        // Ready on the very cycle the timeout would fire; faulty ready bit differs
        run_vec(vec, int'(TO) + 2, '0, brdy, 1'b0, 0);

        // Reset during WAIT
        @(posedge clk); #1;
        tv_data  = vec;
        tv_valid = 1'b1;
        @(posedge clk); #1 tv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_dut_tv", dut_tv, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_mismatch", res_mismatch, 0);
        chk("arst_timeout", res_timeout, 0);
        chk("arst_err_cnt", err_cnt, 0);
        mdl_cnt[0] = '0;
        mdl_cnt[1] = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("arst_tv_ready", tv_ready, 1);
        run_vec(vec, 5, '0, b3, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
